// File: rtl/ef_pwm32_capture_pkg.sv
// ef_pwm32_capture_pkg: shared FSM state type and default sizing for the PWM capture block
package ef_pwm32_capture_pkg;
    localparam int DEF_CNT_W = 32;
    localparam int DEF_SYNC_STAGES = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, MEAS = 2'd2} state_t;
endpackage

// File: rtl/ef_pwm32_sync_edge.sv
// ef_pwm32_sync_edge: synchronises the asynchronous PWM input and flags rising/falling edges
module ef_pwm32_sync_edge
    import ef_pwm32_capture_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic din,
    output logic sync_level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic prev;
    // shift the input through the synchroniser and keep a one-cycle-old copy of its output
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end
    assign sync_level = sync[SYNC_STAGES-1];
    assign rise = sync_level & ~prev;
    assign fall = ~sync_level & prev;
endmodule

// File: rtl/ef_pwm32_capture.sv
// ef_pwm32_capture: measures PWM period and high time in PCLK cycles with a one-deep result channel
module ef_pwm32_capture
    import ef_pwm32_capture_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             en,
    input  logic             pwm_in,
    input  logic [CNT_W-1:0] timeout,
    input  logic             clr,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             overflow,
    output logic             overrun,
    output logic             stall,
    output logic             level
);
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, idle_cnt, hi;
    logic hi_ovf, sync_level, rise, fall, any_edge;
    logic cnt_sat, idle_sat, stall_hit, new_res, hold;

    ef_pwm32_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .din(pwm_in),
        .sync_level(sync_level),
        .rise(rise),
        .fall(fall)
    );

    assign any_edge = rise | fall;
    assign cnt_sat = &cnt;
    assign idle_sat = &idle_cnt;
    // an edge in the same cycle restarts the idle count, so it takes priority over a stall
    assign stall_hit = en && state != IDLE && !any_edge && timeout != '0 && idle_cnt == timeout;
    assign new_res = en && state == MEAS && rise;
    assign hold = meas_valid && !meas_ready;

    // next state: disable dominates, a stall drops back to waiting for a fresh rise
    always_comb begin
        state_nxt = !en ? IDLE : stall_hit ? ARM : state == IDLE ? ARM : rise ? MEAS : state;
    end

    // FSM, free-running saturating counters and captured high time
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
            cnt <= '0;
            idle_cnt <= '0;
            hi <= '0;
            hi_ovf <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
            cnt <= '0;
            idle_cnt <= '0;
            hi <= '0;
            hi_ovf <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= rise ? CNT_W'(1) : cnt_sat ? cnt : cnt + CNT_W'(1);
            idle_cnt <= any_edge ? CNT_W'(1) : idle_sat ? idle_cnt : idle_cnt + CNT_W'(1);
            if (fall && state == MEAS) begin
                hi <= cnt;
                hi_ovf <= cnt_sat;
            end
        end
    end

    // result register, sticky overrun and stall/level status
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            meas_valid <= 1'b0;
            period <= '0;
            high_time <= '0;
            overflow <= 1'b0;
            overrun <= 1'b0;
            stall <= 1'b0;
            level <= 1'b0;
        end else begin
            if (clr) overrun <= 1'b0;
            if (new_res && hold) overrun <= 1'b1;
            if (!en) begin
                meas_valid <= 1'b0;
                stall <= 1'b0;
                level <= 1'b0;
            end else begin
                meas_valid <= new_res | hold;
                if (new_res) begin
                    period <= cnt;
                    high_time <= hi;
                    overflow <= cnt_sat | hi_ovf;
                end
                if (stall_hit) begin
                    stall <= 1'b1;
                    level <= sync_level;
                end else if (any_edge || clr) begin
                    stall <= 1'b0;
                    level <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ef_pwm32_capture.sv
// tb_ef_pwm32_capture: directed scoreboard bench for the PWM capture block
module tb_ef_pwm32_capture;
    logic PCLK = 1'b0, PRESETn = 1'b0, en = 1'b0, pwm = 1'b0, pwm8 = 1'b0, clr = 1'b0, rdy = 1'b0, rdy8 = 1'b0;
    logic [31:0] timeout = '0;
    logic [7:0] timeout8 = '0;
    logic meas_valid, overflow, overrun, stall, level;
    logic [31:0] period, high_time;
    logic valid8, ovf8, overrun8, stall8, level8;
    logic [7:0] period8, high8;

    typedef struct {
        logic [31:0] p;
        logic [31:0] h;
        logic        o;
    } res_t;
    res_t q[$];
    int t = 0, t_rise = 0, hi_m = 0, nvec = 0, nerr = 0;
    bit have_prev = 0;

    ef_pwm32_capture #(.CNT_W(32), .SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .en(en), .pwm_in(pwm), .timeout(timeout), .clr(clr),
        .meas_ready(rdy), .meas_valid(meas_valid), .period(period), .high_time(high_time),
        .overflow(overflow), .overrun(overrun), .stall(stall), .level(level)
    );

    ef_pwm32_capture #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .PCLK(PCLK), .PRESETn(PRESETn), .en(en), .pwm_in(pwm8), .timeout(timeout8), .clr(clr),
        .meas_ready(rdy8), .meas_valid(valid8), .period(period8), .high_time(high8),
        .overflow(ovf8), .overrun(overrun8), .stall(stall8), .level(level8)
    );

    initial forever #5 PCLK = ~PCLK;

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        res_t r;
        @(negedge PCLK);
        if (meas_valid && rdy) begin
            if (q.size() == 0) check1("spurious_result", 32'(meas_valid), 32'd0);
            else begin
                r = q.pop_front();
                check1("period", period, r.p);
                check1("high_time", high_time, r.h);
                check1("overflow", 32'(overflow), 32'(r.o));
            end
        end
        @(posedge PCLK);
        #1;
        t++;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic rise();
        res_t r;
        pwm = 1'b1;
        if (have_prev) begin
            if (!rdy && q.size() > 0) void'(q.pop_back());
            r.p = 32'(t - t_rise);
            r.h = 32'(hi_m);
            r.o = 1'b0;
            q.push_back(r);
        end
        t_rise = t;
        have_prev = 1;
    endtask

    task automatic fall();
        pwm = 1'b0;
        hi_m = t - t_rise;
    endtask

    task automatic cyc(input int p, input int h, input int n);
        repeat (n) begin
            rise();
            hold(h);
            fall();
            hold(p - h);
        end
    endtask

    initial begin
        hold(2);
        check1("rst_valid", 32'(meas_valid), 0);
        check1("rst_period", period, 0);
        check1("rst_high", high_time, 0);
        check1("rst_overflow", 32'(overflow), 0);
        check1("rst_overrun", 32'(overrun), 0);
        check1("rst_stall", 32'(stall), 0);
        check1("rst_level", 32'(level), 0);
        PRESETn = 1'b1;
        en = 1'b1;
        rdy = 1'b1;
        hold(3);
        cyc(10, 3, 5);
        cyc(10, 7, 4);
        rise();
        hold(3);
        fall();
        hold(2);
        rdy = 1'b0;
        hold(5);
        rise();
        hold(5);
        fall();
        hold(7);
        rise();
        hold(5);
        check1("ovr_valid", 32'(meas_valid), 1);
        check1("ovr_period", period, 12);
        check1("ovr_high", high_time, 5);
        check1("ovr_flag", 32'(overrun), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check1("clr_overrun", 32'(overrun), 0);
        check1("clr_valid_held", 32'(meas_valid), 1);
        rdy = 1'b1;
        hold(2);
        fall();
        timeout = 32'd50;
        hold(20);
        rise();
        hold(52);
        check1("stall_early", 32'(stall), 0);
        tick();
        have_prev = 0;
        check1("stall_set", 32'(stall), 1);
        check1("stall_level", 32'(level), 1);
        hold(7);
        fall();
        hold(2);
        check1("stall_held", 32'(stall), 1);
        tick();
        check1("stall_clear", 32'(stall), 0);
        check1("level_clear", 32'(level), 0);
        hold(4);
        rise();
        hold(4);
        fall();
        hold(6);
        rise();
        hold(6);
        timeout = '0;
        rdy = 1'b0;
        hold(3);
        fall();
        hold(6);
        rise();
        hold(5);
        check1("pre_rst_valid", 32'(meas_valid), 1);
        #2;
        PRESETn = 1'b0;
        #1;
        check1("arst_valid", 32'(meas_valid), 0);
        check1("arst_period", period, 0);
        check1("arst_high", high_time, 0);
        check1("arst_overflow", 32'(overflow), 0);
        check1("arst_overrun", 32'(overrun), 0);
        check1("arst_stall", 32'(stall), 0);
        q.delete();
        have_prev = 0;
        pwm = 1'b0;
        hold(2);
        PRESETn = 1'b1;
        rdy = 1'b1;
        hold(4);
        rise();
        hold(3);
        fall();
        hold(5);
        rise();
        hold(6);
        pwm8 = 1'b1;
        hold(100);
        pwm8 = 1'b0;
        hold(200);
        pwm8 = 1'b1;
        hold(5);
        check1("w8_valid", 32'(valid8), 1);
        check1("w8_period", 32'(period8), 255);
        check1("w8_high", 32'(high8), 100);
        check1("w8_overflow", 32'(ovf8), 1);
        check1("w8_overrun", 32'(overrun8), 0);
        en = 1'b0;
        tick();
        check1("dis_valid8", 32'(valid8), 0);
        check1("dis_valid", 32'(meas_valid), 0);
        hold(3);
        check1("queue_drained", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/ef_pwm32_capture.md
# ef_pwm32_capture

PWM capture/decoder for the EF_PWM32 family: samples an external PWM waveform and measures period and high time in PCLK cycles. It is the receiving end of the waveform a PWM32 timer generates, and is used as an on-chip duty/frequency monitor and as a loop-back checker for pwmA/pwmB. Results leave on a valid/ready channel with overflow, overrun and stall status.

## Interface
Parameters:
- CNT_W, 32, width of period/high/idle counters and result fields
- SYNC_STAGES, 2, flip-flop stages synchronising pwm_in (min 2)

Ports:
- PCLK  in  1  clock, all logic rising-edge
- PRESETn  in  1  reset, asynchronous, active-low
- en  in  1  capture enable; low forces IDLE
- pwm_in  in  1  asynchronous PWM input
- timeout  in  CNT_W  cycles without any edge before stall; 0 disables
- clr  in  1  one-cycle pulse; clears overrun and stall
- meas_ready  in  1  consumer accepts result
- meas_valid  out  1  result available
- period  out  CNT_W  rise-to-rise cycles
- high_time  out  CNT_W  rise-to-fall cycles
- overflow  out  1  result field saturated; qualified by meas_valid
- overrun  out  1  sticky: unread result overwritten
- stall  out  1  no edge for timeout cycles
- level  out  1  synchronised level while stall=1, else 0

## Operation
- pwm_in passes through SYNC_STAGES flops; edges detected by comparing the synchroniser output with its 1-cycle-delayed copy.
- FSM: IDLE (en=0) -> ARM on en=1; ARM -> MEAS on rise; MEAS -> MEAS on rise (result emitted); ARM/MEAS -> ARM on stall; any -> IDLE on en=0.
- cnt: loaded with 1 on a rise cycle, else cnt+1, saturating at all-ones. Rise in MEAS: period <= cnt. Fall in MEAS: hi <= cnt. Falls in ARM are ignored.
- overflow = cnt saturated at the rise, or at the fall that set hi.
- Result channel, one-deep: transfer on meas_valid & meas_ready. New result while meas_valid & !meas_ready: overwrite, overrun <= 1. New result in the same cycle as a transfer: old result transferred, new one loaded, meas_valid stays 1, no overrun.
- idle_cnt counts cycles since the last edge of either polarity. idle_cnt == timeout (timeout != 0) in ARM/MEAS: stall <= 1, level <= sync level, FSM -> ARM, partial measurement discarded. The next edge clears stall.
- en=0: counters, meas_valid, stall, level cleared. overrun kept.
- clr: clears overrun and stall. Same-cycle overrun set by a new result wins over clr.
- Reset: meas_valid, period, high_time, overflow, overrun, stall, level = 0. FSM = IDLE. Synchroniser flops = 0.

## Timing
- A pwm_in transition meeting setup at edge E0 appears at the synchroniser output after SYNC_STAGES edges. Edge detect is combinational in that cycle. meas_valid/period/high_time update at the next edge (SYNC_STAGES+1 edges after E0).
- Measurement resolution is 1 PCLK cycle. Minimum measurable high or low phase is 1 cycle; shorter pulses may be lost.
- stall asserts timeout cycles after the detect cycle of the last edge.
- Outputs are registered. meas_valid never drops without a transfer, except on en=0 or reset.
- Reset mid-measurement: outputs go to 0 immediately. After release, the first result needs two new rises.

## Structure
- Package ef_pwm32_capture_pkg: FSM state enum (IDLE, ARM, MEAS) and default CNT_W/SYNC_STAGES constants.
- Sub-module ef_pwm32_sync_edge: SYNC_STAGES synchroniser plus rise/fall detect, outputs sync_level, rise, fall.
- Top holds the FSM, counters and result register.

## Test plan
- en=1, meas_ready=1, pwm period 10 cycles, high 3 -> after the second rise, period=10, high_time=3, overflow=0; one result every 10 cycles.
- Switch high time to 7 mid-stream -> first full cycle afterwards reports 10/7; no spurious result.
- meas_ready=0 across two results (10/3 then 12/5) -> meas_valid held, data 12/5, overrun=1. clr -> overrun=0.
- CNT_W=8, period 300, high 100 -> period=255, high_time=100, overflow=1.
- timeout=50, pwm held high 60 cycles -> stall=1, level=1 exactly 50 cycles after the last edge detect. Next fall clears stall; no result until two further rises.
- PRESETn low during MEAS -> all outputs 0 asynchronously. After release with en=1, no result until the second new rise.
